// File: rtl/clr_skid_buffer.sv
// Two-entry valid/ready register slice with synchronous clear.
// Upstream ready comes only from registered occupancy, so there is no iRdy->oRdy path.
module clr_skid_buffer #(
    parameter int unsigned           WIDTH    = 32,
    parameter logic [WIDTH-1:0]      INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    input  logic [WIDTH-1:0] iDat,
    output logic             oRdy,
    output logic             oVld,
    output logic [WIDTH-1:0] oDat,
    input  logic             iRdy,
    output logic [1:0]       oCnt
);

    // Encoding equals occupancy so oCnt is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNxt;
    logic [WIDTH-1:0] mainQ;
    logic [WIDTH-1:0] mainNxt;
    logic [WIDTH-1:0] skidQ;
    logic [WIDTH-1:0] skidNxt;
    logic             acc;
    logic             pop;

    assign oVld = (state != EMPTY);
    assign oRdy = (state != FULL);
    assign oCnt = state;
    assign oDat = mainQ;

    assign acc = iVld & oRdy;
    assign pop = oVld & iRdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            mainQ <= INI_DATA;
            skidQ <= INI_DATA;
        end else begin
            state <= stateNxt;
            mainQ <= mainNxt;
            skidQ <= skidNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        mainNxt  = mainQ;
        skidNxt  = skidQ;
        if (iClr) begin
            // Flush wins over any concurrent accept or pop.
            stateNxt = EMPTY;
            mainNxt  = INI_DATA;
            skidNxt  = INI_DATA;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        mainNxt  = iDat;
                        stateNxt = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        mainNxt = iDat;
                    end else if (acc) begin
                        skidNxt  = iDat;
                        stateNxt = FULL;
                    end else if (pop) begin
                        stateNxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        mainNxt  = skidQ;
                        stateNxt = ONE;
                    end
                end
                default: stateNxt = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_clr_skid_buffer.sv
// Randomized bench for clr_skid_buffer against a queue-based FIFO model.
module tb_clr_skid_buffer;

    localparam int unsigned      WIDTH = 32;
    localparam logic [WIDTH-1:0] INI   = 32'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic             iClr;
    logic             iVld;
    logic [WIDTH-1:0] iDat;
    logic             oRdy;
    logic             oVld;
    logic [WIDTH-1:0] oDat;
    logic             iRdy;
    logic [1:0]       oCnt;

    int nVec = 0;
    int nBad = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] lastHead;

    clr_skid_buffer #(.WIDTH(WIDTH), .INI_DATA(INI)) dut (
        .clk (clk),
        .rst (rst),
        .iClr(iClr),
        .iVld(iVld),
        .iDat(iDat),
        .oRdy(oRdy),
        .oVld(oVld),
        .oDat(oDat),
        .iRdy(iRdy),
        .oCnt(oCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chkAll(input string tag);
        chk({tag, ".vld"}, 32'(oVld), 32'(mq.size() > 0));
        chk({tag, ".rdy"}, 32'(oRdy), 32'(mq.size() < 2));
        chk({tag, ".cnt"}, 32'(oCnt), 32'(mq.size()));
        chk({tag, ".dat"}, oDat, (mq.size() > 0) ? mq[0] : lastHead);
    endtask

    task automatic modelReset();
        mq.delete();
        lastHead = INI;
    endtask

    // Called at negedge: drive, take one rising edge, update model, check at next negedge.
    task automatic step(input string tag, input logic clr, input logic vld,
                        input logic [WIDTH-1:0] dat, input logic rdy);
        bit canAcc;
        bit canPop;
        iClr = clr;
        iVld = vld;
        iDat = dat;
        iRdy = rdy;
        canAcc = vld && (mq.size() < 2);
        canPop = rdy && (mq.size() > 0);
        @(posedge clk);
        if (clr) begin
            modelReset();
        end else begin
            if (canPop) void'(mq.pop_front());
            if (canAcc) mq.push_back(dat);
            if (mq.size() > 0) lastHead = mq[0];
        end
        @(negedge clk);
        chkAll(tag);
    endtask

    initial begin
        rst  = 1'b0;
        iClr = 1'b0;
        iVld = 1'b0;
        iDat = '0;
        iRdy = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst.vld", 32'(oVld), 32'd0);
        chk("rst.rdy", 32'(oRdy), 32'd1);
        chk("rst.cnt", 32'(oCnt), 32'd0);
        chk("rst.dat", oDat, 32'h1);

        // Streaming at full rate
        for (int k = 1; k <= 4; k++) begin
            step("stream", 1'b0, 1'b1, WIDTH'(k), 1'b1);
            chk("stream.dat_k", oDat, 32'(k));
        end
        step("drain", 1'b0, 1'b0, '0, 1'b1);

        // Backpressure: third beat must not be taken
        step("bp0", 1'b0, 1'b1, 32'd10, 1'b0);
        step("bp1", 1'b0, 1'b1, 32'd11, 1'b0);
        chk("bp.full_cnt", 32'(oCnt), 32'd2);
        chk("bp.full_dat", oDat, 32'd10);
        step("bp2", 1'b0, 1'b1, 32'd12, 1'b0);
        chk("bp.stall_dat", oDat, 32'd10);
        step("bp3", 1'b0, 1'b1, 32'd12, 1'b1);
        chk("bp.second", oDat, 32'd11);
        step("bp4", 1'b0, 1'b1, 32'd12, 1'b1);
        chk("bp.third", oDat, 32'd12);
        step("bp5", 1'b0, 1'b0, '0, 1'b1);

        // Clear while full drops the concurrent beat
        step("cf0", 1'b0, 1'b1, 32'd20, 1'b0);
        step("cf1", 1'b0, 1'b1, 32'd21, 1'b0);
        step("cf2", 1'b1, 1'b1, 32'd22, 1'b1);
        chk("clr.dat", oDat, 32'h1);
        chk("clr.cnt", 32'(oCnt), 32'd0);
        step("cf3", 1'b0, 1'b0, '0, 1'b1);

        // Simultaneous accept and pop in ONE
        step("ap0", 1'b0, 1'b1, 32'd5, 1'b0);
        step("ap1", 1'b0, 1'b1, 32'd6, 1'b1);
        chk("ap.dat", oDat, 32'd6);
        chk("ap.cnt", 32'(oCnt), 32'd1);
        step("ap2", 1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset between edges while stalled full
        step("ar0", 1'b0, 1'b1, 32'd30, 1'b0);
        step("ar1", 1'b0, 1'b1, 32'd31, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst.vld", 32'(oVld), 32'd0);
        chk("arst.rdy", 32'(oRdy), 32'd1);
        chk("arst.cnt", 32'(oCnt), 32'd0);
        chk("arst.dat", oDat, 32'h1);
        modelReset();
        iVld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chkAll("arst.rel");

        // Random traffic with occasional clears
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 WIDTH'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/clr_skid_buffer.md
Name: clr_skid_buffer

Overview:
- Two-entry valid/ready register slice with synchronous clear.
- Sits directly downstream of the clear/reset-configurable data register: it takes that register's output as iDat and forwards it to a consumer that may stall.
- Decouples the ready timing: upstream oRdy is derived only from registered state, with no combinational path from iRdy.
- Gives full throughput (one beat per cycle) with one cycle of latency.

Parameters:
WIDTH, 32, data width of iDat/oDat.
INI_DATA, 0, value loaded into both data entries on reset and on iClr; must fit in WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-low.
iClr  input  1  synchronous clear/flush, active-high.
iVld  input  1  upstream beat valid.
iDat  input  WIDTH  upstream beat data.
oRdy  output  1  upstream ready; a beat transfers when iVld&oRdy&!iClr at the edge.
oVld  output  1  downstream beat valid.
oDat  output  WIDTH  downstream beat data (main entry).
iRdy  input  1  downstream ready; a beat pops when oVld&iRdy&!iClr at the edge.
oCnt  output  2  occupancy: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives oDat) plus skid entry. State is EMPTY (oCnt=0), ONE (oCnt=1) or FULL (oCnt=2).
- Derived outputs:
  - oVld = (state != EMPTY).
  - oRdy = (state != FULL).
  - oCnt is taken directly from the state register.
  - None of these depend combinationally on iVld or iRdy.
- Reset (rst low, asynchronous): state=EMPTY, main=skid=INI_DATA. So oVld=0, oRdy=1, oDat=INI_DATA, oCnt=0. Normal operation resumes at the first rising edge after rst returns high.
- Define acc = iVld&oRdy and pop = oVld&iRdy.
- EMPTY:
  - acc: main<=iDat, go to ONE.
  - otherwise: hold.
- ONE:
  - acc & !pop: skid<=iDat, go to FULL.
  - pop & !acc: go to EMPTY; main retains its value.
  - acc & pop: main<=iDat, stay in ONE.
  - neither: hold.
- FULL (oRdy=0, so acc is impossible):
  - pop: main<=skid, go to ONE.
  - otherwise: hold. Main and skid must be stable while stalled.
- Ordering: beats leave in exactly the order accepted. No loss, no duplication.
- Latency: a beat accepted at edge N appears on oDat/oVld right after edge N. Sustained throughput is 1 beat/cycle when iRdy stays high.
- iClr (synchronous) has highest priority:
  - At the edge: state<=EMPTY, main<=INI_DATA, skid<=INI_DATA.
  - Any concurrent iVld beat is dropped, and any concurrent pop is not counted as a transfer.
  - Upstream treats a clear cycle as a flush.
- rst has priority over iClr.
- When EMPTY, oDat holds its last value (INI_DATA after reset or clear). Consumers must qualify oDat with oVld.
- Reset asserted mid-transfer: contents are discarded immediately and all outputs take their reset values asynchronously.
- When the pipeline is FULL, iDat/iVld are ignored.

Test Plan:
- Reset with INI_DATA=32'h1: hold rst low 2 cycles, release -> oVld=0, oRdy=1, oCnt=0, oDat=32'h1.
- Streaming: iRdy=1, iVld=1, iDat=1,2,3,4 on consecutive cycles -> oDat=1,2,3,4 one cycle later with oVld=1 throughout, oCnt stays 1, oRdy stays 1.
- Backpressure: iRdy=0, push 10, 11, 12 -> after 2 edges oCnt=2, oRdy=0, oDat=10. Beat 12 is not accepted. Raise iRdy -> oDat=10, then 11, then 12 once re-offered, in order.
- Clear while FULL: entries 20, 21, then iClr=1 with iVld=1, iDat=22 -> next cycle oCnt=0, oVld=0, oDat=32'h1, and 22 never appears.
- Simultaneous acc/pop in ONE: main=5, iVld=1, iDat=6, iRdy=1 -> oDat=6, oCnt=1, no skid use.
- Async reset mid-stall: FULL with 30, 31, drop rst between edges -> outputs return to reset values immediately, without waiting for clk.
